apmu_ibex_regfile_dump: RTL and testbench
=========================================

# apmu_ibex_regfile_dump

Sequential reader that walks every architectural register of the Ibex register file through one asynchronous read port and streams each (index, value) pair out over a valid/ready interface. It sits between the core's register file and the APMU context-capture logic. It borrows a read port only when the core grants it, so a full-register snapshot needs no extra RAM ports. It is the reader-side counterpart of the FPGA register file's write port.

## Interface
- RV32E, 0: 1 = 16 registers (x0–x15), 0 = 32 registers.
- DataWidth, 32: register width.
- SkipZero, 1: 1 = never read or emit x0; 0 = emit x0 as a beat whose data is rf_rdata_i.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- dump_req_i  in  1  start request; sampled only in IDLE.
- abort_i  in  1  cancel the dump in progress; no done pulse is produced.
- dump_busy_o  out  1  high whenever the state is not IDLE.
- dump_done_o  out  1  one-cycle pulse after the last beat is accepted.
- rf_req_o  out  1  read-port request; high in READ.
- rf_gnt_i  in  1  core grants the read port this cycle.
- rf_raddr_o  out  5  read address; 0 outside READ; bit 4 is 0 when RV32E=1.
- rf_rdata_i  in  DataWidth  asynchronous read data for rf_raddr_o, valid in the same cycle.
- dump_valid_o  out  1  output beat valid.
- dump_ready_i  in  1  consumer accepts the beat.
- dump_addr_o  out  5  register index of the beat.
- dump_data_o  out  DataWidth  register value of the beat.

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE, dump_req_i=1 → READ. The address counter loads SkipZero ? 1 : 0.
- READ: rf_raddr_o = counter.
  - Capture condition: rf_gnt_i && (!dump_valid_o || dump_ready_i).
  - On capture, the output register loads {counter, rf_rdata_i} and dump_valid_o=1.
  - If counter == NUM_WORDS-1, go to DRAIN; otherwise increment counter.
- Without a capture, counter and rf_raddr_o hold.
- DRAIN: dump_valid_o && dump_ready_i → valid clears, go to DONE.
- DONE: dump_done_o=1 for exactly one cycle, then → IDLE.
- Outside a capture, a beat is cleared by acceptance (valid && ready). A beat is never dropped.
- While dump_valid_o && !dump_ready_i, dump_addr_o and dump_data_o are held stable.
- dump_req_i is ignored while busy. A request in the DONE cycle is also ignored.
- abort_i in any non-IDLE state:
  - next state is IDLE;
  - dump_valid_o clears;
  - no capture happens that cycle;
  - no done pulse is produced.
- abort_i has priority over every other transition.
- Counter width is 5 bits. NUM_WORDS = RV32E ? 16 : 32. The counter never wraps: DRAIN is taken at the last index.

## Timing
- Reset values:
  - state IDLE;
  - dump_busy_o, dump_done_o, rf_req_o, dump_valid_o = 0;
  - rf_raddr_o, dump_addr_o = 0;
  - dump_data_o = 0.
- Reset asserted mid-dump returns to IDLE at once, with the same values.
- Request sampled in cycle 0 → READ in cycle 1.
- Register k is captured at the end of the grant cycle; its beat is valid the next cycle (1-cycle latency).
- Throughput is 1 beat/cycle with rf_gnt_i=1 and dump_ready_i=1.
- Full run, 32 registers, SkipZero=1, no stalls:
  - beats valid in cycles 2..32 (x1..x31);
  - DRAIN in cycle 32;
  - done in cycle 33;
  - IDLE in cycle 34;
  - busy in cycles 1..33.
- A simultaneous accept of the old beat and capture of a new beat is legal: the output register is overwritten in the same cycle.

## Structure
- Package apmu_pkg:
  - dump state enum (IDLE, READ, DRAIN, DONE);
  - RegAddrW = 5 localparam;
  - beat struct {addr, data}.
- No sub-module. The single-entry output register is inline; a generic buffer is not justified for one entry.

## Test plan
- Full dump, SkipZero=1, x1..x31 preloaded with 0x100+i, gnt=1, ready=1 → 31 beats, (i, 0x100+i) in order, cycles 2..32; done in cycle 33.
- Backpressure: ready low for 3 cycles at beat x5 → x5 held stable; no skipped or duplicate index; done arrives 3 cycles late.
- rf_gnt_i toggling every other cycle → rf_raddr_o held while ungranted; beats still x1..x31 in order.
- RV32E=1, SkipZero=0 → 16 beats, x0..x15; rf_raddr_o[4] always 0.
- abort_i at beat x10 → valid drops next cycle; busy=0; no done; a new request restarts at x1.
- rst_ni low mid-dump, and dump_req_i pulsed while busy → all outputs at reset values; the extra request causes no second dump.

Source files
------------

// File: rtl/apmu_ibex_regfile_dump_pkg.sv
// Shared types for the APMU register-file dump path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apmu_pkg;

    // Dump sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } dump_state_e;

    // Register index width of the Ibex register file (x0..x31).
    localparam int unsigned RegAddrW = 5;

    // Native Ibex register width, used by consumers of the beat stream.
    localparam int unsigned RegDataW = 32;

    // One streamed (index, value) pair at the native register width.
    typedef struct packed {
        logic [RegAddrW-1:0] addr;
        logic [RegDataW-1:0] data;
    } beat_t;

endpackage

// File: rtl/apmu_ibex_regfile_dump.sv
// Walks every architectural register through one borrowed async read port and streams (index, value) beats.
// Latency: beat valid one cycle after the granted read; 1 beat/cycle with continuous grant and ready.
// Backpressure: single output register; read only captured when the slot is empty or being accepted, beat held while !ready.
//
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   dump_req_i, abort_i            start (IDLE only) / cancel without done pulse
//   dump_busy_o, dump_done_o       not-IDLE flag, one-cycle completion pulse
//   rf_req_o, rf_gnt_i             read-port request/grant handshake
//   rf_raddr_o, rf_rdata_i         read address, same-cycle read data
//   dump_valid_o, dump_ready_i     output beat handshake
//   dump_addr_o, dump_data_o       beat payload
module apmu_ibex_regfile_dump
    import apmu_pkg::*;
#(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32,
    parameter bit          SkipZero  = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 dump_req_i,
    input  logic                 abort_i,
    output logic                 dump_busy_o,
    output logic                 dump_done_o,
    output logic                 rf_req_o,
    input  logic                 rf_gnt_i,
    output logic [RegAddrW-1:0]  rf_raddr_o,
    input  logic [DataWidth-1:0] rf_rdata_i,
    output logic                 dump_valid_o,
    input  logic                 dump_ready_i,
    output logic [RegAddrW-1:0]  dump_addr_o,
    output logic [DataWidth-1:0] dump_data_o
);

    // Beat layout sized by the instance data width.
    typedef struct packed {
        logic [RegAddrW-1:0]  addr;
        logic [DataWidth-1:0] data;
    } beat_w_t;

    localparam logic [RegAddrW-1:0] FirstIdx = SkipZero ? 5'd1 : 5'd0;
    localparam logic [RegAddrW-1:0] LastIdx  = RV32E ? 5'd15 : 5'd31;

    dump_state_e         state_q, state_d;
    logic [RegAddrW-1:0] cnt_q;
    beat_w_t             beat_q;
    logic                vld_q;
    logic                abort_act;
    logic                capture;

    assign abort_act = abort_i && (state_q != ST_IDLE);

    // A read is only taken when the output slot is free or drains this cycle,
    // so a beat can never be overwritten before it is accepted.
    assign capture = (state_q == ST_READ) && rf_gnt_i
                     && (!vld_q || dump_ready_i) && !abort_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (dump_req_i) state_d = ST_READ;
            ST_READ:  if (capture && (cnt_q == LastIdx)) state_d = ST_DRAIN;
            ST_DRAIN: if (vld_q && dump_ready_i) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort_act) begin
            state_d = ST_IDLE;
        end
    end

    // State-decoded outputs
    always_comb begin
        dump_busy_o = (state_q != ST_IDLE);
        dump_done_o = (state_q == ST_DONE);
        rf_req_o    = (state_q == ST_READ);
        rf_raddr_o  = (state_q == ST_READ) ? cnt_q : '0;
    end

    // Address counter: loads the first index on start, advances per capture and
    // stops at the last index instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if ((state_q == ST_IDLE) && dump_req_i) begin
            cnt_q <= FirstIdx;
        end else if (capture && (cnt_q != LastIdx)) begin
            cnt_q <= cnt_q + 5'd1;
        end
    end

    // Single-entry output register. Payload only changes on capture, so it is
    // stable while a beat waits for ready.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= 1'b0;
            beat_q <= '0;
        end else if (abort_act) begin
            vld_q <= 1'b0;
        end else if (capture) begin
            vld_q       <= 1'b1;
            beat_q.addr <= cnt_q;
            beat_q.data <= rf_rdata_i;
        end else if (vld_q && dump_ready_i) begin
            vld_q <= 1'b0;
        end
    end

    assign dump_valid_o = vld_q;
    assign dump_addr_o  = beat_q.addr;
    assign dump_data_o  = beat_q.data;

endmodule

// File: tb/tb_apmu_ibex_regfile_dump.sv
module tb_apmu_ibex_regfile_dump;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, req, abort_s, gnt, rdy, sel;
    logic [31:0] rf [32];

    // Instance A: 32 registers, SkipZero=1. Instance E: RV32E, SkipZero=0.
    logic        a_busy, a_done, a_rfreq, a_vld;
    logic [4:0]  a_raddr, a_addr;
    logic [31:0] a_rdata, a_data;
    logic        e_busy, e_done, e_rfreq, e_vld;
    logic [4:0]  e_raddr, e_addr;
    logic [31:0] e_rdata, e_data;

    assign a_rdata = rf[a_raddr];
    assign e_rdata = rf[e_raddr];

    apmu_ibex_regfile_dump #(.RV32E(1'b0), .DataWidth(32), .SkipZero(1'b1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .dump_req_i(req), .abort_i(abort_s),
        .dump_busy_o(a_busy), .dump_done_o(a_done), .rf_req_o(a_rfreq), .rf_gnt_i(gnt),
        .rf_raddr_o(a_raddr), .rf_rdata_i(a_rdata), .dump_valid_o(a_vld),
        .dump_ready_i(rdy), .dump_addr_o(a_addr), .dump_data_o(a_data));

    apmu_ibex_regfile_dump #(.RV32E(1'b1), .DataWidth(32), .SkipZero(1'b0)) dut_e (
        .clk_i(clk), .rst_ni(rst_n), .dump_req_i(req), .abort_i(abort_s),
        .dump_busy_o(e_busy), .dump_done_o(e_done), .rf_req_o(e_rfreq), .rf_gnt_i(gnt),
        .rf_raddr_o(e_raddr), .rf_rdata_i(e_rdata), .dump_valid_o(e_vld),
        .dump_ready_i(rdy), .dump_addr_o(e_addr), .dump_data_o(e_data));

    // Observed instance selected by sel (0 = A, 1 = E).
    logic        o_busy, o_done, o_req, o_vld;
    logic [4:0]  o_raddr, o_addr;
    logic [31:0] o_data;
    assign o_busy  = sel ? e_busy  : a_busy;
    assign o_done  = sel ? e_done  : a_done;
    assign o_req   = sel ? e_rfreq : a_rfreq;
    assign o_vld   = sel ? e_vld   : a_vld;
    assign o_raddr = sel ? e_raddr : a_raddr;
    assign o_addr  = sel ? e_addr  : a_addr;
    assign o_data  = sel ? e_data  : a_data;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_a_busy", a_busy, 0);   chk("rst_e_busy", e_busy, 0);
        chk("rst_a_done", a_done, 0);   chk("rst_e_done", e_done, 0);
        chk("rst_a_rfreq", a_rfreq, 0); chk("rst_e_rfreq", e_rfreq, 0);
        chk("rst_a_vld", a_vld, 0);     chk("rst_e_vld", e_vld, 0);
        chk("rst_a_raddr", a_raddr, 0); chk("rst_e_raddr", e_raddr, 0);
        chk("rst_a_addr", a_addr, 0);   chk("rst_e_addr", e_addr, 0);
        chk("rst_a_data", a_data, 0);   chk("rst_e_data", e_data, 0);
    endtask

    // Let both instances run to completion with an always-ready consumer.
    task automatic flush();
        req = 0; abort_s = 0; gnt = 1; rdy = 1;
        repeat (40) @(posedge clk);
        #1;
    endtask

    // One dump on the selected instance. Cycle 0 is the request cycle.
    // mode 0: gnt=ready=1; 1: ready low 3 cycles at beat x5; 2: gnt every other
    // cycle; 3: random gnt/ready. abort_beat >= 0 aborts when that beat is shown.
    task automatic run_dump(input int mode, input int abort_beat,
                            output int nbeats, output int first_cyc,
                            output int last_cyc, output int done_cyc);
        int cyc, exp_idx, stall_left;
        bit stalled, prev_stall, prev_req, prev_gnt, aborted;
        logic [4:0]  prev_addr, prev_raddr;
        logic [31:0] prev_data;
        exp_idx = sel ? 0 : 1;
        nbeats = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
        stall_left = 0; stalled = 0; prev_stall = 0; prev_req = 0; prev_gnt = 0;
        aborted = 0; prev_addr = 0; prev_raddr = 0; prev_data = 0;
        req = 1; gnt = 0; rdy = 0; abort_s = 0;
        @(posedge clk); #1;
        req = 0; cyc = 1;
        while (cyc < 400) begin
            chk("busy_during", o_busy, 1);
            if (prev_stall) begin
                chk("hold_vld", o_vld, 1);
                chk("hold_addr", o_addr, prev_addr);
                chk("hold_data", o_data, prev_data);
            end
            if (prev_req && !prev_gnt && o_req) chk("raddr_hold", o_raddr, prev_raddr);
            if (sel && o_req) chk("raddr_bit4", o_raddr[4], 0);
            if (o_done) begin
                done_cyc = cyc;
                break;
            end
            case (mode)
                0: begin gnt = 1; rdy = 1; end
                1: begin
                    gnt = 1;
                    if (o_vld && o_addr == 5'd5 && !stalled) begin
                        stalled = 1; stall_left = 3;
                    end
                    rdy = (stall_left == 0);
                    if (stall_left > 0) stall_left--;
                end
                2: begin gnt = (cyc % 2 == 1); rdy = 1; end
                default: begin
                    gnt = ($urandom_range(0, 3) != 0);
                    rdy = ($urandom_range(0, 2) != 0);
                end
            endcase
            req = (cyc == 5);  // request while busy must be ignored
            if (abort_beat >= 0 && o_vld && o_addr == abort_beat[4:0]) begin
                abort_s = 1; rdy = 0; aborted = 1;
            end
            if (o_vld && rdy) begin
                chk("beat_addr", o_addr, exp_idx);
                chk("beat_data", o_data, rf[exp_idx]);
                if (nbeats == 0) first_cyc = cyc;
                last_cyc = cyc;
                exp_idx++;
                nbeats++;
            end
            prev_stall = o_vld && !rdy && !aborted;
            prev_addr = o_addr; prev_data = o_data;
            prev_req = o_req; prev_gnt = gnt; prev_raddr = o_raddr;
            @(posedge clk); #1;
            cyc++;
            if (aborted) break;
        end
        req = 0; abort_s = 0;
        if (aborted) begin
            chk("abort_vld", o_vld, 0);
            chk("abort_busy", o_busy, 0);
            repeat (5) begin
                @(posedge clk); #1;
                chk("abort_no_done", o_done, 0);
            end
        end else begin
            chk("done_seen", (done_cyc >= 0), 1);
            // A request in the DONE cycle must not start a new dump.
            req = 1;
            @(posedge clk); #1;
            req = 0;
            chk("done_one_cycle", o_done, 0);
            chk("idle_after_done", o_busy, 0);
        end
    endtask

    int nb, fc, lc, dc;

    initial begin
        rst_n = 0; req = 0; abort_s = 0; gnt = 0; rdy = 0; sel = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals();
        rst_n = 1;
        @(posedge clk); #1;

        // Full dump, no stalls: beats 2..32, done 33.
        sel = 0;
        run_dump(0, -1, nb, fc, lc, dc);
        chk("full_nbeats", nb, 31);
        chk("full_first_cyc", fc, 2);
        chk("full_last_cyc", lc, 32);
        chk("full_done_cyc", dc, 33);
        flush();

        // Backpressure at x5 for 3 cycles: done 3 cycles later.
        run_dump(1, -1, nb, fc, lc, dc);
        chk("bp_nbeats", nb, 31);
        chk("bp_done_cyc", dc, 36);
        flush();

        // Grant every other cycle.
        run_dump(2, -1, nb, fc, lc, dc);
        chk("gnt_toggle_nbeats", nb, 31);
        flush();

        // RV32E, x0 included: 16 beats in cycles 2..17, done 18.
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        sel = 1;
        run_dump(0, -1, nb, fc, lc, dc);
        chk("e_nbeats", nb, 16);
        chk("e_first_cyc", fc, 2);
        chk("e_last_cyc", lc, 17);
        chk("e_done_cyc", dc, 18);
        flush();

        // Abort while x10 is presented, then restart from x1.
        sel = 0;
        run_dump(0, 10, nb, fc, lc, dc);
        chk("abort_nbeats", nb, 9);
        run_dump(0, -1, nb, fc, lc, dc);
        chk("restart_nbeats", nb, 31);
        chk("restart_done_cyc", dc, 33);
        flush();

        // Random grant/ready on both configurations.
        for (int r = 0; r < 4; r++) begin
            sel = r[0];
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            run_dump(3, -1, nb, fc, lc, dc);
            chk("rand_nbeats", nb, sel ? 16 : 31);
            flush();
        end

        // Reset mid-dump with a stray request while busy.
        sel = 0;
        req = 1; gnt = 1; rdy = 1;
        @(posedge clk); #1;
        req = 0;
        repeat (6) @(posedge clk);
        #1;
        chk("mid_busy", o_busy, 1);
        req = 1;
        @(posedge clk); #1;
        req = 0;
        rst_n = 0;
        #1;
        chk_reset_vals();
        @(posedge clk); #1;
        rst_n = 1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("no_second_dump", o_busy, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
